// File: rtl/fetch_unit_if.sv
// fetch_unit_if: redirect, instruction BRAM and decode handshake signals of the fetch stage
interface fetch_unit_if #(
    parameter int IMEM_AW = 14
);
    logic               redirect_valid;
    logic [63:0]        redirect_pc;
    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [63:0]        out_pc;
    logic [31:0]        out_instr;
    logic [63:0]        debug_fetch_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_rdata, out_ready,
        output imem_en, imem_addr, out_valid, out_pc, out_instr, debug_fetch_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_rdata, out_ready,
        input  imem_en, imem_addr, out_valid, out_pc, out_instr, debug_fetch_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, 1-cycle BRAM fetch and a 2-entry instruction queue toward decode
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          IMEM_AW  = 14
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic        inflight_q, inflight_d;
    logic [63:0] inflight_pc_q, inflight_pc_d;
    logic [63:0] pc_q [2];
    logic [63:0] pc_d [2];
    logic [31:0] instr_q [2];
    logic [31:0] instr_d [2];
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        valid, deq, enq, issue;
    logic [63:0] req_pc;

    // next-state: redirect flushes the queue and drops returning data; issue keeps a slot per request
    always_comb begin
        valid         = (count_q != 2'd0);
        deq           = valid & bus.out_ready;
        enq           = inflight_q & ~bus.redirect_valid;
        req_pc        = bus.redirect_valid ? (bus.redirect_pc & ~64'h3) : fetch_pc_q;
        issue         = ~reset & (bus.redirect_valid |
                        (({1'b0, count_q} + {2'b0, inflight_q} - {2'b0, deq}) < 3'd2));
        count_d       = bus.redirect_valid ? 2'd0 : count_q + {1'b0, enq} - {1'b0, deq};
        rd_ptr_d      = bus.redirect_valid ? wr_ptr_q : rd_ptr_q ^ deq;
        wr_ptr_d      = wr_ptr_q ^ enq;
        fetch_pc_d    = issue ? req_pc + 64'd4 : fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? req_pc : inflight_pc_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        if (enq) begin
            pc_d[wr_ptr_q]    = inflight_pc_q;
            instr_d[wr_ptr_q] = bus.imem_rdata;
        end
        bus.imem_en        = issue;
        bus.imem_addr      = reset ? '0 : req_pc[IMEM_AW+1:2];
        bus.out_valid      = valid;
        bus.out_pc         = pc_q[rd_ptr_q];
        bus.out_instr      = instr_q[rd_ptr_q];
        bus.debug_fetch_pc = fetch_pc_q;
    end

    // state registers; reset discards everything queued or in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 64'h0;
            pc_q          <= '{2{64'h0}};
            instr_q       <= '{2{32'h0}};
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the pipelined RV64 CPU, sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC and drives the synchronous instruction BRAM, which has one cycle of read latency. It buffers returned instructions in a 2-entry queue and presents them to decode over a valid/ready handshake. It accepts PC redirects from branch/jump resolution, and on a redirect it flushes all wrong-path instructions.

## Interface
- `RESET_PC`, default 64'h0: fetch address after reset.
- `IMEM_AW`, default 14: BRAM word-address width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `redirect_valid` in 1: taken branch/jump; load a new fetch PC this cycle.
- `redirect_pc` in 64: redirect target; bits [1:0] are ignored and treated as 0.
- `imem_en` out 1: BRAM read enable, one request per asserted cycle.
- `imem_addr` out IMEM_AW: word address, equal to request PC[IMEM_AW+1:2].
- `imem_rdata` in 32: BRAM data for the request issued in the previous cycle.
- `out_valid` out 1: an instruction is available to decode.
- `out_ready` in 1: decode accepts the instruction this cycle.
- `out_pc` out 64: PC of the presented instruction.
- `out_instr` out 32: the presented instruction.
- `debug_fetch_pc` out 64: PC of the next request to issue.

## Operation
- **State:**
  - `fetch_pc` (64b).
  - `inflight` (1b): a request was issued last cycle.
  - `inflight_pc` (64b).
  - 2-entry FIFO of {pc, instr}, with `count` from 0 to 2.
- **Dequeue:** `deq = out_valid & out_ready`. The head is popped on `deq`. `out_pc` and `out_instr` show the FIFO head, and `out_valid = (count != 0)`.
- **Enqueue:** when `inflight` is set and this is not a redirect cycle, {`inflight_pc`, `imem_rdata`} is written to the FIFO tail at the clock edge.
- **Issue (no redirect):** `imem_en = 1` iff `count + inflight - deq < 2`. On issue:
  - `imem_addr = fetch_pc[IMEM_AW+1:2]`
  - `inflight_pc <= fetch_pc`
  - `fetch_pc <= fetch_pc + 4`, modulo 2^64
  - `inflight <= 1`
  
  Without issue, `inflight <= 0`.
- **Redirect (`redirect_valid = 1`, not in reset):**
  - The FIFO is cleared (`count <= 0`).
  - The `imem_rdata` returned this cycle is discarded.
  - A request is issued this same cycle at `{redirect_pc[63:2], 2'b00}`: `imem_en = 1`, `inflight <= 1`, `inflight_pc` = that PC, `fetch_pc` = that PC + 4.
  - Redirect has priority over enqueue.
  - If `deq` occurs in the redirect cycle, the handshake still completes; decode is responsible for squashing that instruction.
- **Reset:** reset overrides redirect, issue and dequeue.
- **Backpressure:**
  - While `out_valid & !out_ready`, `out_pc` and `out_instr` hold stable.
  - The FIFO never overflows: the issue rule reserves a slot for every in-flight request.
- **Back-to-back redirects:** each redirect discards the previous redirect's in-flight data. Only the last redirect's stream appears at the output.

## Timing
- **Reset values:**
  - Outputs: `out_valid = 0`, `imem_en = 0`, `imem_addr = 0`, `out_pc = 0`, `out_instr = 0`, `debug_fetch_pc = RESET_PC`.
  - Internal state: `count = 0`, `inflight = 0`.
- **Startup:** reset is deasserted before cycle 0.
  - Cycle 0: request issued for RESET_PC.
  - Cycle 1: data arrives.
  - Cycle 2: `out_valid = 1` with `out_pc = RESET_PC`.
- **Redirect latency:** a redirect sampled in cycle t produces `out_valid` with `out_pc` = target in cycle t+2. `out_valid` is 0 in cycle t+1.
- **Steady state:** with `out_ready` held at 1, one instruction is delivered per cycle with consecutive PCs.
- **Stall release:** with `out_ready` low, the FIFO fills to 2 and `imem_en` drops to 0. When `out_ready` rises, delivery resumes at 1 per cycle with no bubble and no duplicated or skipped PC.
- **Reset mid-operation:** all queued and in-flight instructions are discarded. Behaviour then matches startup.

## Test plan
- **Reset/startup:** RESET_PC=0x100, BRAM word i = 0x1000_0000+i, `out_ready = 1`. Required:
  - `out_valid` first in cycle 2.
  - `out_pc` sequence 0x100, 0x104, 0x108…
  - `out_instr` sequence 0x1000_0040, 0x1000_0041…
- **Backpressure:** `out_ready = 0` for 5 cycles starting with 0x104 presented. Required:
  - `out_pc` holds 0x104.
  - `imem_en = 0` once count = 2.
  - After release, `out_pc` sequence 0x104, 0x108, 0x10C with no gaps.
- **Redirect:** `redirect_valid` with `redirect_pc = 0x2002` in cycle t. Required:
  - `imem_addr = 0x800` in cycle t.
  - `out_valid = 0` in cycle t+1.
  - `out_pc = 0x2000` in cycle t+2, then 0x2004.
  - No old-path PC appears after t.
- **Redirect under stall:** FIFO full, `out_ready = 0`, redirect to 0x300. Required:
  - FIFO flushed.
  - `out_pc = 0x300` in cycle t+2.
- **Back-to-back redirects:** 0x400 in cycle t, 0x500 in cycle t+1. Required: 0x400 is never presented, and `out_pc = 0x500` in cycle t+3.
- **Wrap and reset:**
  - Redirect to 0xFFFF_FFFF_FFFF_FFFC. Required: `out_pc` sequence 0x…FFFC then 0x0.
  - Assert `reset` mid-stream. Required: `out_valid = 0` next cycle, then restart at RESET_PC.
